// File: rtl/rv4028_bus_sram.sv
// Halfword SRAM target for the RV4028 16-bit external bus.
// Address-phase decode and latch, wait-stated reads, byte-masked single-cycle writes.
module rv4028_bus_sram #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_STATES = 0,
    parameter bit          IO_SPACE    = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [1:0]  wr_n,
    input  logic        rd_n,
    input  logic [1:0]  msk_n,
    input  logic        iorq_n,
    input  logic [1:0]  mreq_n,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_oe,
    output logic        wait_n
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RDATA = 2'd1,
        WDATA = 2'd2
    } state_e;

    state_e                 state_q;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [1:0]             msk_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [15:0]            data_out_q;
    logic                   data_oe_q;
    logic                   wait_n_q;
    logic [15:0]            mem_q [DEPTH];

    logic                   sel_c;
    logic [ADDR_BITS-1:0]   idx_c;
    logic                   unused_bits;

    assign sel_c = !mreq_n[1] && (iorq_n == !IO_SPACE)
                && (addr[31:ADDR_BITS+1] == BASE_ADDR[31:ADDR_BITS+1]);
    assign idx_c = addr[ADDR_BITS:1];
    assign unused_bits = ^{addr[0], mreq_n[0]};

    // Bus FSM; outputs are registered so they change only on clock edges (or reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            msk_q      <= 2'b11;
            cnt_q      <= '0;
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
            wait_n_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_c && (wr_n != 2'b11)) begin
                        idx_q   <= idx_c;
                        msk_q   <= msk_n;
                        state_q <= WDATA;
                    end else if (sel_c && !rd_n) begin
                        idx_q      <= idx_c;
                        cnt_q      <= CNT_W'(WAIT_STATES);
                        data_out_q <= mem_q[idx_c];
                        data_oe_q  <= 1'b1;
                        wait_n_q   <= (WAIT_STATES == 0);
                        state_q    <= RDATA;
                    end
                end
                RDATA: begin
                    // rd_n rising mid-wait aborts; otherwise finish once the count is spent.
                    if (rd_n || (cnt_q == '0)) begin
                        cnt_q     <= '0;
                        data_oe_q <= 1'b0;
                        wait_n_q  <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q    <= cnt_q - CNT_W'(1);
                        wait_n_q <= (cnt_q == CNT_W'(1));
                    end
                end
                WDATA: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Storage is not reset; an async reset forces IDLE so a pending write never commits.
    always_ff @(posedge clk) begin
        if (state_q == WDATA) begin
            if (!msk_q[0]) mem_q[idx_q][7:0]  <= data_in[7:0];
            if (!msk_q[1]) mem_q[idx_q][15:8] <= data_in[15:8];
        end
    end

    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;
    assign wait_n   = wait_n_q;

endmodule
